// File: rtl/timing_decode_unit_pkg.sv
// ============================================================================
// Module   : timing_decode_unit_pkg
// Purpose  : Shared constants for the basic-computer timing/decode unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package timing_decode_unit_pkg;

  localparam int unsigned SC_W   = 3;
  localparam int unsigned T_W    = 8;
  localparam int unsigned IR_W   = 16;
  localparam int unsigned ADDR_W = 12;

  localparam int unsigned OP_AND    = 0;
  localparam int unsigned OP_ADD    = 1;
  localparam int unsigned OP_LDA    = 2;
  localparam int unsigned OP_STA    = 3;
  localparam int unsigned OP_BUN    = 4;
  localparam int unsigned OP_BSA    = 5;
  localparam int unsigned OP_ISZ    = 6;
  localparam int unsigned OP_REG_IO = 7;

  localparam int unsigned T0 = 0;
  localparam int unsigned T1 = 1;
  localparam int unsigned T2 = 2;
  localparam int unsigned T3 = 3;
  localparam int unsigned T4 = 4;
  localparam int unsigned T5 = 5;
  localparam int unsigned T6 = 6;

  localparam int unsigned HALT_BIT = 0;

  localparam int unsigned T_END_REG_IO = 3;
  localparam int unsigned T_END_SHORT  = 4;
  localparam int unsigned T_END_LONG   = 5;
  localparam int unsigned T_END_MAX    = 6;

  typedef struct packed {
    logic              ind;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic logic [T_W-1:0] onehot8(input logic [2:0] idx);
    onehot8 = T_W'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timing_decode_unit_seq_counter.sv
// ============================================================================
// Module   : seq_counter
// Purpose  : 3-bit sequence counter with clear/increment and gated one-hot out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_counter
  import timing_decode_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_inc,
  input  logic            i_en,
  output logic [SC_W-1:0] o_cnt,
  output logic [T_W-1:0]  o_onehot
);

  logic [SC_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + SC_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_onehot = i_en ? onehot8(r_cnt) : '0;

endmodule

`default_nettype wire

// File: rtl/timing_decode_unit.sv
// ============================================================================
// Module   : timing_decode_unit
// Purpose  : Run/halt state, T-step generation, T2 IR decode latch, end-of-
//            instruction detection for the basic-computer control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timing_decode_unit
  import timing_decode_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [IR_W-1:0]   i_ir,
  output logic [T_W-1:0]    o_T,
  output logic [7:0]        o_D,
  output logic              o_I,
  output logic [ADDR_W-1:0] o_B,
  output logic              o_running,
  output logic              o_halted,
  output logic              o_instr_done,
  output logic [SC_W-1:0]   o_sc
);

  logic              r_running;
  logic              r_halted;
  logic [7:0]        r_D;
  logic              r_I;
  logic [ADDR_W-1:0] r_B;

  logic [SC_W-1:0]   w_sc;
  logic [T_W-1:0]    w_T;
  logic              w_start;
  logic              w_end;
  logic              w_halt;
  logic              w_latch;
  instr_t            w_ir;

  assign w_ir    = instr_t'(i_ir);
  assign w_start = i_start & ~r_running;
  assign w_latch = r_running & (w_sc == SC_W'(T2));

  // w_T is already gated by r_running, so every term implies running.
  assign w_end = (r_D[OP_REG_IO] & w_T[T_END_REG_IO])
               | ((r_D[OP_AND] | r_D[OP_ADD] | r_D[OP_LDA]) & w_T[T_END_LONG])
               | ((r_D[OP_STA] | r_D[OP_BUN]) & w_T[T_END_SHORT])
               | (r_D[OP_BSA] & w_T[T_END_LONG])
               | w_T[T_END_MAX];

  assign w_halt = r_D[OP_REG_IO] & ~r_I & w_T[T3] & r_B[HALT_BIT];

  seq_counter u_seq_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_end | w_start),
    .i_inc    (r_running & ~w_end),
    .i_en     (r_running),
    .o_cnt    (w_sc),
    .o_onehot (w_T)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else if (w_start) begin
      r_running <= 1'b1;
      r_halted  <= 1'b0;
    end else if (w_halt) begin
      r_running <= 1'b0;
      r_halted  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_D <= '0;
      r_I <= 1'b0;
      r_B <= '0;
    end else if (w_latch) begin
      r_D <= onehot8(w_ir.op);
      r_I <= w_ir.ind;
      r_B <= w_ir.addr;
    end
  end

  assign o_T          = w_T;
  assign o_D          = r_D;
  assign o_I          = r_I;
  assign o_B          = r_B;
  assign o_running    = r_running;
  assign o_halted     = r_halted;
  assign o_instr_done = w_end;
  assign o_sc         = w_sc;

endmodule

`default_nettype wire

// File: doc/timing_decode_unit.md
# timing_decode_unit

Generates the timing and decode inputs that the basic-computer control unit consumes. It holds a 3-bit sequence counter (SC) and the run/halt state, and produces one-hot timing `T[7:0]`. It registers the IR decode at T2 and drives `D[7:0]`, `I` and `B[11:0]`. It also finds the last timing step of each instruction and clears SC there, so the control unit stays purely combinational.

## Interface
- No parameters; widths are fixed by the 16-bit instruction format.
- `clk` in 1: single system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request. Sampled only while not running.
- `ir` in 16: current datapath IR contents (loaded by `irLD` at T1).
- `T` out 8: one-hot timing `T[sc]` while running. All zero while stopped.
- `D` out 8: one-hot decode of opcode `ir[14:12]`, registered at T2.
- `I` out 1: indirect/type bit `ir[15]`, registered at T2.
- `B` out 12: `ir[11:0]`, registered at T2.
- `running` out 1: S flip-flop.
- `halted` out 1: set by HLT, cleared by `start` or `rst`.
- `instr_done` out 1: high during the final timing cycle of each instruction.
- `sc` out 3: raw sequence-counter value, for debug.

## Operation
- **Reset values:** `sc`=0, `running`=0, `halted`=0, `D`=0, `I`=0, `B`=0. This gives `T`=0 and `instr_done`=0.
- **Start:** `start` while `running`=0 sets `running`=1, `halted`=0 and `sc`=0 on the next edge. `T` is `8'h01` in the following cycle. `start` while running has no effect.
- **T generation:** `T` = `running` ? `1<<sc` : 0. This is combinational from registers.
- **Decode latch:** on the edge that ends T2 (`running` & `sc`==2):
  - `D` <= `1<<ir[14:12]`
  - `I` <= `ir[15]`
  - `B` <= `ir[11:0]`
  - These values hold until the next T2.
- **End condition `e`**, evaluated with `running`=1 and registered D/I/B:
  - D7 & T3: register-reference or I/O.
  - (D0|D1|D2) & T5: AND, ADD, LDA.
  - (D3|D4) & T4: STA, BUN.
  - D5 & T5: BSA.
  - T6: unconditional, covering ISZ and acting as a safety stop.
- **SC update:**
  - `e` true: `sc` <= 0.
  - Otherwise, when running: `sc` <= `sc`+1.
  - Not running: `sc` holds 0.
- **`instr_done`** = `e`.
- **Halt:** D7 & ~I & T3 & `B[0]` ends the instruction and also clears `running` and sets `halted` on the same edge. `T`=0 from the next cycle.
- **Instruction lengths, in cycles, T0 included:**
  - register-reference / I/O: 4
  - STA, BUN: 5
  - AND, ADD, LDA, BSA: 6
  - ISZ: 7
- **Reset mid-instruction:** `rst` overrides every other input. All outputs return to reset values on that edge, regardless of `sc` or `start`.

## Timing
- Zero-latency combinational path from `sc`/`running` to `T` and `instr_done`. There is no combinational path from `ir` to any output.
- D/I/B are valid from T3 onward. During T0–T2 they still show the previous instruction, which the control unit does not use then.
- After `start`: first T0 appears one cycle later.
- After HLT: T3 is the last active cycle, then `T`=0.
- Back-to-back instructions: T0 of the next instruction immediately follows the end cycle. There are no bubble cycles.
- `sc` never reaches 7. T6 always clears it.

## Structure
- **Shared package** holds:
  - Opcode constants: `OP_AND`=0 … `OP_REG_IO`=7.
  - T-index constants.
  - Halt bit index: 0.
  - End-step constants per opcode group: 3/4/5/6.
- **Sub-module `seq_counter`:** 3-bit counter with synchronous `rst`, `clr` and `inc`, plus a one-hot decode output gated by an `en` input. The top level holds S/halted, the decode registers and the end logic.
- **Estimated size:** about 150 RTL lines.

## Test plan
- **Reset and start:** reset, then `start` pulse → `T`=01, 02, 04, 08 on consecutive cycles. With `ir`=16'h7800 (CLA), after T3 `D`=80, `I`=0, `B`=12'h800, and `instr_done`=1 in the T3 cycle.
- **Memory-reference lengths:**
  - `ir`=16'h2010 (LDA): `T` sequence T0..T5, `instr_done` at T5, next cycle `T`=01.
  - `ir`=16'h6020 (ISZ): ends at T6, `D`=40.
  - `ir`=16'h1005 (ADD): ends at T5.
  - `ir`=16'h3005 (STA): ends at T4.
  - `ir`=16'h4005 (BUN): ends at T4.
  - `ir`=16'h5005 (BSA): ends at T5.
- **Indirect:** `ir`=16'h8123 → `I`=1, `D`=01, `B`=12'h123 from T3; ends at T5.
- **Halt:** `ir`=16'h7001 → at T3 `instr_done`=1. Next cycle `T`=0, `running`=0, `halted`=1. `sc` stays 0 for 10 idle cycles. A `start` pulse then gives `T`=01 and `halted`=0.
- **Start while running:** `start` asserted at T2 of LDA → no change to the sequence.
- **Reset mid-instruction:** `rst` at T4 of ISZ → next cycle all outputs are zero and `running`=0. A simultaneous `start` and `rst` also gives reset state.
